// File: rtl/dpsk_pkg.sv
// Shared DPSK definitions: FSM states, default symbol length and the carrier
// pattern, used by both the modulator and the demodulator.
package dpsk_pkg;

    typedef enum logic [0:0] {
        S_ACQ = 1'b0,
        S_RUN = 1'b1
    } state_t;

    localparam int DEF_SYM_CLKS = 16;

    // Phase-0 carrier read MSB first: 0,0,1,1 over one 4-clock carrier period.
    localparam logic [3:0] CARRIER = 4'b0011;

    function automatic logic carrier_bit(input logic [1:0] phase);
        return CARRIER[2'd3 - phase];
    endfunction

endpackage

// File: rtl/dpsk_correlator.sv
// Symbol-phase counter, local carrier reference and mismatch accumulator.
// count includes the current sample so a decision can be registered at sym_end.
module dpsk_correlator
    import dpsk_pkg::*;
#(
    parameter  int SYM_CLKS = DEF_SYM_CLKS,
    localparam int PW       = $clog2(SYM_CLKS),
    localparam int CW       = $clog2(SYM_CLKS) + 1
) (
    input  logic          clk,
    input  logic          start,
    input  logic          x,
    output logic          sym_end,
    output logic [CW-1:0] count
);

    localparam logic [PW-1:0] LAST_PH = PW'(SYM_CLKS - 1);

    logic [PW-1:0] ph;
    logic [CW-1:0] acc;
    logic          ref_bit;
    logic          mm;

    // Reference, per-sample mismatch and running total including this sample.
    always_comb begin
        ref_bit = carrier_bit(ph[1:0]);
        mm      = x ^ ref_bit;
        count   = acc + {{(CW-1){1'b0}}, mm};
        sym_end = (ph == LAST_PH);
    end

    // Phase counter and accumulator; the accumulator restarts right after the last sample.
    always_ff @(posedge clk) begin
        if (!start) begin
            ph  <= {PW{1'b0}};
            acc <= {CW{1'b0}};
        end else if (sym_end) begin
            ph  <= {PW{1'b0}};
            acc <= {CW{1'b0}};
        end else begin
            ph  <= ph + {{(PW-1){1'b0}}, 1'b1};
            acc <= count;
        end
    end

endmodule

// File: rtl/dpsk_demodulator.sv
// DPSK demodulator: per-symbol correlation, threshold decision and differential
// decode. Define DPSK_DIFF_DECODE_EN for differential decode; otherwise y is absolute CPSK.
module dpsk_demodulator
    import dpsk_pkg::*;
#(
    parameter  int SYM_CLKS = DEF_SYM_CLKS,
    parameter  int THRESH   = SYM_CLKS / 2,
    localparam int CW       = $clog2(SYM_CLKS) + 1
) (
    input  logic          clk,
    input  logic          start,
    input  logic          x,
    output logic          y,
    output logic          y_valid,
    output logic          ambig,
    output logic [CW-1:0] corr
);

    localparam logic [CW-1:0] THR = CW'(THRESH);

    logic          sym_end;
    logic [CW-1:0] count;
    logic          rel;
    logic          rel_next;
    logic          tie;
    state_t        state;

    dpsk_correlator #(
        .SYM_CLKS (SYM_CLKS)
    ) u_corr (
        .clk     (clk),
        .start   (start),
        .x       (x),
        .sym_end (sym_end),
        .count   (count)
    );

    // Threshold decision; a tie keeps the previous relative bit.
    always_comb begin
        tie      = 1'b0;
        rel_next = rel;
        if (count > THR) begin
            rel_next = 1'b1;
        end else if (count < THR) begin
            rel_next = 1'b0;
        end else begin
            rel_next = rel;
            tie      = 1'b1;
        end
    end

`ifdef DPSK_DIFF_DECODE_EN
    logic rel_prev;

    // Acquisition seeds rel_prev from the first symbol; afterwards every symbol decodes.
    always_ff @(posedge clk) begin
        if (!start) begin
            state    <= S_ACQ;
            rel      <= 1'b0;
            rel_prev <= 1'b0;
            y        <= 1'b0;
            y_valid  <= 1'b0;
            ambig    <= 1'b0;
            corr     <= {CW{1'b0}};
        end else begin
            y_valid <= 1'b0;
            if (sym_end) begin
                rel  <= rel_next;
                corr <= count;
                case (state)
                    S_ACQ: begin
                        rel_prev <= tie ? 1'b0 : rel_next;
                        state    <= S_RUN;
                    end
                    S_RUN: begin
                        y        <= rel_next ^ rel_prev;
                        rel_prev <= rel_next;
                        ambig    <= tie;
                        y_valid  <= 1'b1;
                    end
                    default: begin
                        state <= S_ACQ;
                    end
                endcase
            end
        end
    end
`else
    // Absolute decode: every symbol strobes straight from reset.
    always_ff @(posedge clk) begin
        if (!start) begin
            state   <= S_RUN;
            rel     <= 1'b0;
            y       <= 1'b0;
            y_valid <= 1'b0;
            ambig   <= 1'b0;
            corr    <= {CW{1'b0}};
        end else begin
            y_valid <= 1'b0;
            if (sym_end) begin
                rel  <= rel_next;
                corr <= count;
                case (state)
                    S_RUN: begin
                        y       <= rel_next;
                        ambig   <= tie;
                        y_valid <= 1'b1;
                    end
                    default: begin
                        state <= S_RUN;
                    end
                endcase
            end
        end
    end
`endif

endmodule

// File: doc/dpsk_demodulator.md
DPSK_DEMODULATOR -- requirements
Module: dpsk_demodulator

Interface
REQ-001 SHALL have parameter SYM_CLKS, default 16: clocks per symbol; a multiple of 4 and at least 8; one carrier period is 4 clocks.
REQ-002 SHALL have parameter THRESH, default SYM_CLKS/2: decision threshold on the per-symbol mismatch count.
REQ-003 SHALL have port clk  input  1  system clock; the single clock for all logic.
REQ-004 SHALL have port start  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port x  input  1  received PSK line: phase-0 carrier 0,0,1,1 per carrier period, or phase-180 carrier 1,1,0,0.
REQ-006 SHALL have port y  output  1  decoded absolute data bit, held until the next decision.
REQ-007 SHALL have port y_valid  output  1  one-clock strobe marking a new y.
REQ-008 SHALL have port ambig  output  1  asserted with y_valid when the decided symbol was a tie.
REQ-009 SHALL have port corr  output  $clog2(SYM_CLKS)+1  mismatch count of the last completed symbol.

Function
REQ-010 SHALL run a phase counter ph over 0..SYM_CLKS-1, incrementing every clock and wrapping to 0; ph=0 on the first clock with start=1.
REQ-011 SHALL generate the local reference ref = ph[1], giving 0,0,1,1 per carrier period, aligned with the modulator that shares clk and start.
REQ-012 SHALL accumulate mm = x XOR ref each clock; at ph=SYM_CLKS-1 the last sample SHALL be included and the accumulator SHALL restart from 0 on the following clock, with no dead cycle.
REQ-013 SHALL decide on the clock after ph=SYM_CLKS-1: count>THRESH gives rel=1; count<THRESH gives rel=0; count==THRESH holds rel at its previous value and sets ambig=1.
REQ-014 SHALL compute the absolute bit as rel XOR rel_prev, then set rel_prev to rel.
REQ-015 SHALL update y, corr and ambig only at a decision, with y_valid high for exactly that one clock; latency is 1 clock after the last sample of the symbol.
REQ-016 SHALL use FSM states S_ACQ and S_RUN.
  - S_ACQ: decide the first symbol, seed rel_prev, keep y_valid=0, then go to S_RUN.
  - S_RUN: every decision strobes y_valid.
REQ-017 SHALL treat a tie in S_ACQ as seeding rel_prev=0.
REQ-018 SHALL never leave S_RUN except by reset.
REQ-019 SHALL require an all-phase-0 or all-phase-180 line to decode as a continuous run of absolute 0 in S_RUN.

Reset
REQ-020 SHALL, while start=0 on a rising edge, set ph=0, accumulator=0, rel=0, rel_prev=0, y=0, y_valid=0, ambig=0, corr=0 and state=S_ACQ.
REQ-021 SHALL discard a partially accumulated symbol when start goes low mid-symbol, and restart at ph=0 after release.

Configuration
REQ-022 SHALL compile the differential decode in when macro DPSK_DIFF_DECODE_EN is defined: REQ-014 and S_ACQ apply.
REQ-023 SHALL, when DPSK_DIFF_DECODE_EN is undefined:
  - output y=rel (absolute CPSK);
  - reset into S_RUN;
  - strobe y_valid from the first symbol;
  - omit rel_prev.

Structure
REQ-024 SHALL place the state enum, default SYM_CLKS, and the carrier pattern constant 4'b0011 in shared package dpsk_pkg, reused by the modulator.
REQ-025 SHALL instantiate one sub-module, dpsk_correlator, containing ph, ref, the accumulator, and a sym_end pulse output.

Verification
REQ-026 SHALL cover: diff enabled, phases 0,180,180,0,0 with SYM_CLKS=16 -> no strobe for symbol 0; y=1,0,1,0 with y_valid at clocks 32,48,64,80; corr=16,16,0,0.
REQ-027 SHALL cover: first symbol with 8 mismatches, then 180 -> corr=8; rel_prev seeded 0; next decision y=1, ambig=0.
REQ-028 SHALL cover: in S_RUN, rel=1 then a tie symbol -> y=0, ambig=1, y_valid=1 for one clock.
REQ-029 SHALL cover: start low for 1 clock at ph=9 -> all outputs 0 next clock; the next y_valid appears exactly 32 clocks after release.
REQ-030 SHALL cover: diff disabled, phases 180,0 -> y=1 at clock 16 and y=0 at clock 32, y_valid at both.
REQ-031 SHALL cover: modulator feeding demodulator in loopback with 200 random absolute bits -> y equals the input delayed by 1 symbol plus 1 clock, with zero errors and ambig never set.
